// File: rtl/cv32e40s_integrity_alert.sv
// Integrity alert aggregator: edge-detects hardening error flags, pulses a minor
// alert per event and escalates to a reset-only LOCKED state via a leaky bucket.
module cv32e40s_integrity_alert #(
  parameter int unsigned          NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0]   MAJOR_MASK  = 4'b0001,
  parameter int unsigned          THRESHOLD   = 4,
  parameter int unsigned          LEAK_PERIOD = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SRC-1:0]                 err_src_i,
  output logic                               alert_minor_o,
  output logic                               alert_major_o,
  output logic [NUM_SRC-1:0]                 err_cause_o,
  output logic [$clog2(THRESHOLD+1)-1:0]     err_count_o,
  output logic [1:0]                         state_o
);

  localparam int unsigned CW = $clog2(THRESHOLD + 1);
  localparam int unsigned TW = $clog2(LEAK_PERIOD);

  localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [TW-1:0] LP_MAX  = TW'(LEAK_PERIOD - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    LOCKED = 2'b10
  } state_e;

  state_e               state_q;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   src_qq;
  logic [NUM_SRC-1:0]   cause_q;
  logic [CW-1:0]        count_q;
  logic [TW-1:0]        timer_q;
  logic                 minor_q;

  logic [NUM_SRC-1:0]   new_evt;
  logic                 evt;
  logic                 maj;

  // A source held high registers only its rising edge.
  assign new_evt = src_q & ~src_qq;
  assign evt     = |new_evt;
  assign maj     = |(new_evt & MAJOR_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      src_qq  <= '0;
      cause_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      minor_q <= 1'b0;
    end else begin
      src_q   <= err_src_i;
      src_qq  <= src_q;
      cause_q <= cause_q | new_evt;
      minor_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (maj) begin
            state_q <= LOCKED;
          end else if (evt) begin
            if (THRESHOLD == 1) begin
              state_q <= LOCKED;
              count_q <= THR_C;
            end else begin
              state_q <= ACTIVE;
              count_q <= ONE_C;
              timer_q <= '0;
              minor_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (maj) begin
            state_q <= LOCKED;
          end else if (evt) begin
            // An event always beats a coincident leak tick.
            timer_q <= '0;
            if (count_q + ONE_C == THR_C) begin
              state_q <= LOCKED;
              count_q <= THR_C;
            end else begin
              count_q <= count_q + ONE_C;
              minor_q <= 1'b1;
            end
          end else if (timer_q == LP_MAX) begin
            timer_q <= '0;
            if (count_q == ONE_C) begin
              state_q <= IDLE;
              count_q <= '0;
            end else begin
              count_q <= count_q - ONE_C;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        LOCKED: begin
        end
        default: begin
          state_q <= LOCKED;
        end
      endcase
    end
  end

  assign alert_minor_o = minor_q;
  assign alert_major_o = (state_q == LOCKED);
  assign err_cause_o   = cause_q;
  assign err_count_o   = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cv32e40s_integrity_alert.sv
// Randomized and directed bench for cv32e40s_integrity_alert against a
// cycle-level leaky-bucket reference model.
module tb_cv32e40s_integrity_alert;

  localparam int          NSRC = 4;
  localparam logic [3:0]  MAJ  = 4'b0001;
  localparam int          THR  = 4;
  localparam int          LP   = 1024;

  logic       clk;
  logic       rst;
  logic [3:0] err_src_i;
  logic       alert_minor_o;
  logic       alert_major_o;
  logic [3:0] err_cause_o;
  logic [2:0] err_count_o;
  logic [1:0] state_o;

  cv32e40s_integrity_alert #(
    .NUM_SRC    (NSRC),
    .MAJOR_MASK (MAJ),
    .THRESHOLD  (THR),
    .LEAK_PERIOD(LP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .err_src_i    (err_src_i),
    .alert_minor_o(alert_minor_o),
    .alert_major_o(alert_major_o),
    .err_cause_o  (err_cause_o),
    .err_count_o  (err_count_o),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: 0 = idle, 1 = active, 2 = locked; level is the bucket fill,
  // quiet is the number of event-free active cycles since the last event/entry.
  logic [3:0] hist [$];
  int         m_mode;
  int         m_level;
  int         m_quiet;
  logic [3:0] m_cause;
  logic       m_minor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(4'b0000);
    hist.push_back(4'b0000);
    m_mode  = 0;
    m_level = 0;
    m_quiet = 0;
    m_cause = '0;
    m_minor = 1'b0;
  endtask

  // One clock edge: sources that rose between the two previous samples form the event.
  task automatic model_step(input logic [3:0] in);
    logic [3:0] rose;
    rose    = hist[1] & ~hist[0];
    m_cause = m_cause | rose;
    m_minor = 1'b0;
    if (m_mode != 2) begin
      if ((rose & MAJ) != 0) begin
        m_mode = 2;
      end else if (rose != 0) begin
        m_quiet = 0;
        if (m_level + 1 >= THR) begin
          m_mode  = 2;
          m_level = THR;
        end else begin
          m_level = m_level + 1;
          m_mode  = 1;
          m_minor = 1'b1;
        end
      end else if (m_mode == 1) begin
        m_quiet = m_quiet + 1;
        if (m_quiet == LP) begin
          m_quiet = 0;
          m_level = m_level - 1;
          if (m_level == 0) m_mode = 0;
        end
      end
    end
    void'(hist.pop_front());
    hist.push_back(in);
  endtask

  task automatic check_outputs();
    check("minor", 32'(alert_minor_o), 32'(m_minor));
    check("major", 32'(alert_major_o), 32'(m_mode == 2));
    check("cause", 32'(err_cause_o),   32'(m_cause));
    check("count", 32'(err_count_o),   32'(m_level));
    check("state", 32'(state_o),       32'(m_mode));
  endtask

  task automatic tick(input logic [3:0] in);
    @(negedge clk);
    check_outputs();
    err_src_i = in;
    model_step(in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000);
  endtask

  // Async reset for one full cycle; err_src_i is left as-is across release.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_minor", 32'(alert_minor_o), 32'd0);
    check("rst_major", 32'(alert_major_o), 32'd0);
    check("rst_cause", 32'(err_cause_o),   32'd0);
    check("rst_count", 32'(err_count_o),   32'd0);
    check("rst_state", 32'(state_o),       32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_step(err_src_i);
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] allow;
    int         rate;
    int         len;
    int         n;

    rst       = 1'b1;
    err_src_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    pulse_reset();

    // pc_err single pulse: immediate lockup, no minor alert
    tick(4'b0001);
    idle(3);
    check("t1_major", 32'(alert_major_o), 32'd1);
    check("t1_state", 32'(state_o),       32'd2);
    check("t1_cause", 32'(err_cause_o),   32'd1);
    idle(20);

    // three spaced rf-ecc pulses climb the bucket, the fourth escalates
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      tick(4'b0010);
      idle(4);
    end
    check("t2_count3", 32'(err_count_o),   32'd3);
    check("t2_state1", 32'(state_o),       32'd1);
    check("t2_major0", 32'(alert_major_o), 32'd0);
    tick(4'b0010);
    idle(3);
    check("t2_state2", 32'(state_o),     32'd2);
    check("t2_count4", 32'(err_count_o), 32'd4);

    // stuck-high source counts once, then leaks back to idle
    pulse_reset();
    for (int k = 0; k < 100; k++) tick(4'b0100);
    idle(1030);
    check("t3_count0", 32'(err_count_o), 32'd0);
    check("t3_state0", 32'(state_o),     32'd0);
    check("t3_cause",  32'(err_cause_o), 32'h4);

    // simultaneous sources are one event
    pulse_reset();
    tick(4'b1010);
    idle(3);
    check("t4_count1", 32'(err_count_o), 32'd1);
    check("t4_cause",  32'(err_cause_o), 32'hA);

    // event landing exactly on the leak tick at level 2
    pulse_reset();
    tick(4'b0010);
    idle(5);
    tick(4'b0010);
    tick(4'b0000);
    n = 0;
    while (m_quiet != LP - 2 && n < 2 * LP) begin
      tick(4'b0000);
      n++;
    end
    tick(4'b0010);
    idle(3);
    check("t5_count3", 32'(err_count_o), 32'd3);
    idle(LP + 10);
    check("t5_leaked", 32'(err_count_o), 32'd2);

    // reset while locked with a source held high across release
    pulse_reset();
    tick(4'b0001);
    idle(3);
    tick(4'b0010);
    tick(4'b0010);
    pulse_reset();
    tick(4'b0010);
    tick(4'b0010);
    check("t6_minor", 32'(alert_minor_o), 32'd1);
    tick(4'b0010);
    idle(3);
    check("t6_count1", 32'(err_count_o), 32'd1);

    // randomized segments with varied event density
    for (int seg = 0; seg < 8; seg++) begin
      pulse_reset();
      allow = (seg % 4 == 3) ? 4'b1111 : 4'b1110;
      rate  = $urandom_range(400, 3);
      len   = $urandom_range(3500, 1500);
      cur   = err_src_i;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(rate, 0) == 0) begin
          cur = cur ^ (4'(1 << $urandom_range(3, 0)) & allow);
        end
        if ($urandom_range(9, 0) == 0) cur = cur & allow;
        tick(cur);
      end
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
